// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: length codes, FSM states
// and small helpers for access sizing.
package dmem_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;
    localparam logic [1:0] LEN_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACC_LO,
        ACC_HI,
        RESP
    } state_t;

    // Byte lanes covered by an access of the given length, starting at lane 0.
    function automatic logic [3:0] size_mask(input logic [1:0] len);
        case (len)
            LEN_BYTE: size_mask = 4'b0001;
            LEN_HALF: size_mask = 4'b0011;
            default:  size_mask = 4'b1111;
        endcase
    endfunction

    // An access is split when it runs past the end of its 32-bit word.
    function automatic logic is_split(input logic [1:0] len, input logic [1:0] off);
        return ((len == LEN_HALF) && (off == 2'd3)) ||
               ((len == LEN_WORD) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised backing store with per-byte write enables and a registered
// read port whose output holds its value while no read is requested.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-enabled write and one-cycle registered read.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one byte/half/word load or store at a time,
// inserts wait states, splits word-crossing accesses into two array cycles and
// returns extended load data or an error flag through a valid/ready response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_length,
    input  logic        req_sign,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] DEPTH_L   = 33'(DEPTH_WORDS);
    localparam logic [2:0]  WAIT_INIT = 3'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t        state_q;
    logic [2:0]    wait_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic          write_q;
    logic          sign_q;
    logic          split_q;
    logic [1:0]    len_q;
    logic [1:0]    off_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [31:0]   lo_q;

    logic          accept;
    logic          split_d;
    logic          err_d;
    logic [32:0]   idx_lo_d;
    logic [32:0]   idx_hi_d;

    logic          in_acc;
    logic          arr_hi;
    logic          arr_we;
    logic          arr_re;
    logic [AW-1:0] arr_addr;
    logic [3:0]    arr_be;
    logic [31:0]   arr_wdata;
    logic [31:0]   arr_rdata;
    logic [7:0]    be_span;
    logic [63:0]   wdata_span;

    logic [31:0]   lo_word;
    logic [31:0]   raw;
    logic [31:0]   ext;

    // Request decode: the word index is widened by one bit so that the
    // all-ones index plus one cannot wrap back into range.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign idx_lo_d  = {3'b000, req_addr[31:2]};
    assign idx_hi_d  = idx_lo_d + 33'd1;
    assign split_d   = is_split(req_length, req_addr[1:0]);
    assign err_d     = (req_length == LEN_ILL) || (idx_lo_d >= DEPTH_L) ||
                       (split_d && (idx_hi_d >= DEPTH_L));

    // Store lanes and data laid out across the two touched words; the low
    // half goes out in ACC_LO, the high half in ACC_HI.
    assign be_span    = {4'b0000, size_mask(len_q)} << off_q;
    assign wdata_span = {32'd0, wdata_q} << {off_q, 3'b000};
    assign in_acc     = (state_q == ACC_LO) || (state_q == ACC_HI);
    assign arr_hi     = (state_q == ACC_HI);
    assign arr_addr   = idx_q + AW'(arr_hi);
    assign arr_we     = in_acc && write_q && !rst;
    assign arr_re     = in_acc && !write_q;
    assign arr_be     = arr_hi ? be_span[7:4]     : be_span[3:0];
    assign arr_wdata  = arr_hi ? wdata_span[63:32] : wdata_span[31:0];

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk),
        .re_i    (arr_re),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    // In RESP the array output holds the last word read (the high word for a
    // split load, else the only word) and lo_q holds the low word of a split.
    assign lo_word = split_q ? lo_q : arr_rdata;
    assign raw     = 32'({arr_rdata, lo_word} >> {off_q, 3'b000});

    // Sign or zero extension of the assembled load data.
    always_comb begin
        ext = raw;
        case (len_q)
            LEN_BYTE: ext = {{24{sign_q & raw[7]}},  raw[7:0]};
            LEN_HALF: ext = {{16{sign_q & raw[15]}}, raw[15:0]};
            default:  ext = raw;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = (resp_valid_q && !resp_err_q && !write_q) ? ext : 32'd0;

    // Control FSM: acceptance, wait countdown, access sequencing and response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_q       <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q <= req_write;
                        sign_q  <= req_sign;
                        len_q   <= req_length;
                        off_q   <= req_addr[1:0];
                        idx_q   <= req_addr[AW+1:2];
                        wdata_q <= req_wdata;
                        split_q <= split_d;
                        if (err_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (WAIT_CYCLES > 0) begin
                            state_q <= WAIT;
                            wait_q  <= WAIT_INIT;
                        end else begin
                            state_q <= ACC_LO;
                        end
                    end
                end
                WAIT: begin
                    if (wait_q == 3'd0) begin
                        state_q <= ACC_LO;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                ACC_LO: begin
                    if (split_q) begin
                        state_q <= ACC_HI;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                ACC_HI: begin
                    lo_q         <= arr_rdata;
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic, checked against a byte-addressed reference memory model.
module tb_dmem_responder;

    localparam int WAITC  = 1;
    localparam int DEPTH  = 64;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_length;
    logic        req_sign;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem_b [NBYTES];

    always #5 clk = ~clk;

    dmem_responder #(
        .WAIT_CYCLES (WAITC),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_length (req_length),
        .req_sign   (req_sign),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int sz(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    // Rejected when the length is illegal or the last touched byte lies past the array.
    function automatic logic m_err(input logic [31:0] addr, input logic [1:0] len);
        logic [63:0] last;
        if (len == 2'b11) return 1'b1;
        last = {32'd0, addr} + 64'(sz(len) - 1);
        return last >= 64'(NBYTES);
    endfunction

    function automatic logic m_split(input logic [31:0] addr, input logic [1:0] len);
        return (int'(addr[1:0]) + sz(len)) > 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] len,
                                           input logic sg);
        logic [31:0] v;
        int base, n;
        v    = 32'd0;
        base = int'(addr);
        n    = sz(len);
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[base + i];
        if (sg && n < 4 && v[8*n - 1]) v = v | ((n == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000);
        return v;
    endfunction

    task automatic m_store(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] len);
        int base;
        base = int'(addr);
        for (int i = 0; i < sz(len); i++) mem_b[base + i] = wd[8*i +: 8];
    endtask

    // One complete transaction with resp_ready held high.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] len, input logic sg,
                          output logic [31:0] obs);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, cyc;
        e_err = m_err(addr, len);
        e_rd  = (!e_err && !wr) ? m_load(addr, len, sg) : 32'd0;
        e_lat = e_err ? 1 : (m_split(addr, len) ? WAITC + 3 : WAITC + 2);
        if (!e_err && wr) m_store(addr, wd, len);

        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        req_length = len;
        req_sign   = sg;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) break;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(e_lat));
        chk({tag, "_rdata"}, resp_rdata, e_rd);
        chk({tag, "_err"}, 32'(resp_err), 32'(e_err));
        obs = resp_rdata;
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] obs;
        logic [31:0] exp;
        logic [31:0] a;
        int          cyc;
        int          sel;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_length = 2'b00;
        req_sign   = 1'b0;
        resp_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata,      32'd0);
        chk("rst_resp_err",   32'(resp_err),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Fill the whole array with known random words.
        for (int w = 0; w < DEPTH; w++) begin
            do_req("init", 1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0, obs);
        end

        // Aligned word store and load.
        do_req("st_word_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, obs);
        do_req("ld_word_10", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, obs);
        chk("ld_word_10_lit", obs, 32'hDEAD_BEEF);

        // Byte and half extension.
        do_req("ld_byte_s", 1'b0, 32'h10, 32'd0, 2'b00, 1'b1, obs);
        chk("ld_byte_s_lit", obs, 32'hFFFF_FFEF);
        do_req("ld_byte_u", 1'b0, 32'h10, 32'd0, 2'b00, 1'b0, obs);
        chk("ld_byte_u_lit", obs, 32'h0000_00EF);
        do_req("ld_half_s", 1'b0, 32'h12, 32'd0, 2'b01, 1'b1, obs);
        chk("ld_half_s_lit", obs, 32'hFFFF_DEAD);

        // Split word store and load across words 0x10 / 0x14.
        do_req("st_split_13", 1'b1, 32'h13, 32'h1122_3344, 2'b10, 1'b0, obs);
        do_req("ld_split_13", 1'b0, 32'h13, 32'd0, 2'b10, 1'b0, obs);
        chk("ld_split_13_lit", obs, 32'h1122_3344);
        do_req("ld_word_10b", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, obs);
        chk("ld_word_10b_lit", obs, 32'h44AD_BEEF);
        do_req("ld_word_14", 1'b0, 32'h14, 32'd0, 2'b10, 1'b0, obs);
        do_req("ld_half_split", 1'b0, 32'h17, 32'd0, 2'b01, 1'b1, obs);

        // Error cases: illegal length, end of array, no-wrap at top of address space.
        do_req("st_illegal", 1'b1, 32'h0, 32'hFFFF_FFFF, 2'b11, 1'b0, obs);
        do_req("ld_word_0", 1'b0, 32'h0, 32'd0, 2'b10, 1'b0, obs);
        do_req("ld_past_end", 1'b0, 32'(NBYTES - 2), 32'd0, 2'b10, 1'b0, obs);
        do_req("ld_last_word", 1'b0, 32'(NBYTES - 4), 32'd0, 2'b10, 1'b0, obs);
        do_req("ld_top_word", 1'b0, 32'hFFFF_FFFC, 32'd0, 2'b10, 1'b0, obs);
        do_req("ld_top_half", 1'b0, 32'hFFFF_FFFF, 32'd0, 2'b01, 1'b0, obs);

        // Backpressure: response held while a second request is presented.
        exp = m_load(32'h10, 2'b10, 1'b0);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h10;
        req_length = 2'b10;
        req_sign   = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) break;
        end
        chk("bp_latency", 32'(cyc), 32'(WAITC + 2));
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 32'hA5A5_A5A5;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, exp);
            chk("bp_err", 32'(resp_err), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_release", 32'(resp_valid), 32'd0);
        do_req("bp_no_write", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, obs);

        // Reset during the high half of a split store.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h23;
        req_wdata  = 32'hCAFE_F00D;
        req_length = 2'b10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (WAITC + 2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready),  32'd0);
        chk("mid_rst_rdata", resp_rdata,      32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_b[32'h23] = 8'h0D;
        do_req("mid_rst_lo", 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, obs);
        do_req("mid_rst_hi", 1'b0, 32'h24, 32'd0, 2'b10, 1'b0, obs);

        // Randomized traffic.
        for (int k = 0; k < 150; k++) begin
            sel = int'($urandom_range(0, 7));
            if (sel < 6)       a = 32'($urandom_range(0, NBYTES - 1));
            else if (sel == 6) a = 32'(NBYTES) - 32'($urandom_range(1, 4));
            else               a = $urandom;
            do_req("rand", 1'($urandom_range(0, 1)), a, $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), obs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra wait states inserted before each array access (0..7).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-justified.
REQ-010 SHALL have port req_length  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port req_sign  input  1  1 = sign-extend load data, 0 = zero-extend.
REQ-012 SHALL have port resp_valid  output  1  response available.
REQ-013 SHALL have port resp_ready  input  1  initiator consumes the response.
REQ-014 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  request rejected (illegal length or out-of-range address).

Function
REQ-016 SHALL use FSM states IDLE, WAIT, ACC_LO, ACC_HI, RESP.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted on req_valid && req_ready, latching all req_* fields.
REQ-018 SHALL go from IDLE to WAIT on accept if WAIT_CYCLES>0, else directly to ACC_LO; WAIT counts down WAIT_CYCLES cycles, then goes to ACC_LO.
REQ-019 SHALL treat an access as split when byte offset + size exceeds 4: half at offset 3, or word at offset 1..3.
REQ-020 SHALL go ACC_LO to ACC_HI when split, else to RESP; ACC_HI to RESP.
REQ-021 SHALL read word addr[31:2] in ACC_LO and word addr[31:2]+1 in ACC_HI, then assemble bytes little-endian.
REQ-022 SHALL perform stores as byte-enabled word writes: only the addressed bytes change; a split store writes the low part in ACC_LO and the high part in ACC_HI.
REQ-023 SHALL extend loads per req_sign from bit 7 (byte) or bit 15 (half); words pass unchanged.
REQ-024 SHALL, for illegal length or any touched word index >= DEPTH_WORDS, skip all array writes, go directly to RESP, and return resp_err=1, resp_rdata=0.
REQ-025 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then return to IDLE; the next accept is possible the following cycle.
REQ-026 SHALL give a latency from accept to first resp_valid of WAIT_CYCLES+2 cycles aligned, WAIT_CYCLES+3 split, 1 cycle for errors.
REQ-027 SHALL ignore req_valid outside IDLE; requests are never queued.
REQ-028 SHALL give a word address of all-ones + 1 no wrap: that access is out-of-range and flagged as an error.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, force state IDLE, wait counter 0, req_ready=0 during reset, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-030 SHALL abandon an in-flight request on reset mid-operation; any ACC_LO write already done remains, and an ACC_HI write not yet done is not performed.
REQ-031 SHALL leave array contents unaffected by reset.

Structure
REQ-032 SHALL take the length encodings (LEN_BYTE, LEN_HALF, LEN_WORD) and the FSM state enum from the shared package dmem_pkg.
REQ-033 SHALL instantiate one sub-module dmem_array: DEPTH_WORDS x 32 array, 4-bit byte-enable write, registered one-cycle read.

Verification
REQ-034 SHALL cover aligned word: store 0xDEADBEEF @0x10, then load word @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, first resp_valid 3 cycles after accept (WAIT_CYCLES=1).
REQ-035 SHALL cover byte sign: after REQ-034, load byte @0x10 sign=1 -> 0xFFFFFFEF; sign=0 -> 0x000000EF; load half @0x12 sign=1 -> 0xFFFFDEAD.
REQ-036 SHALL cover split: store word 0x11223344 @0x13, then load word @0x13 -> 0x11223344; words 0x10 and 0x14 each change only the addressed bytes; latency 4 cycles.
REQ-037 SHALL cover errors: length 11 @0x0 -> resp_err=1, rdata=0, no write; word load @(DEPTH_WORDS*4-2) -> resp_err=1.
REQ-038 SHALL cover backpressure: resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0, a second req_valid is ignored.
REQ-039 SHALL cover reset mid-op: rst asserted in ACC_HI of a split store -> IDLE next cycle, resp_valid=0, high word unchanged.
